mp_add_sequencer: RTL



---
 rtl/mp_add_sequencer.sv | 76 +++++++
 1 files changed

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: WORDS-limb adder that reuses one WIDTH-bit add stage, LS limb first
module mp_add_sequencer #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    input  logic                   in_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_sum,
    output logic                   out_carry,
    output logic                   busy
);
    localparam int N  = WIDTH * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   a_reg, b_reg, sum_reg;
    logic           carry_reg;
    logic [IW-1:0]  idx;
    logic           last;
    logic [WIDTH:0] limb_sum;

    assign last      = idx == IW'(WORDS - 1);
    assign limb_sum  = {1'b0, a_reg[idx*WIDTH +: WIDTH]} + {1'b0, b_reg[idx*WIDTH +: WIDTH]}
                     + {{WIDTH{1'b0}}, carry_reg};
    assign out_sum   = sum_reg;
    assign out_carry = carry_reg;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and handshake outputs, decoded from registered state only
    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        case (state)
            IDLE:    state_nx = in_valid  ? RUN  : IDLE;
            RUN:     state_nx = last      ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // operand capture and one limb of addition per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else if (state == IDLE && in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_carry;
            idx       <= '0;
        end else if (state == RUN) begin
            sum_reg[idx*WIDTH +: WIDTH] <= limb_sum[WIDTH-1:0];
            carry_reg                   <= limb_sum[WIDTH];
            if (!last) idx <= idx + 1'b1;
        end
    end
endmodule
